// File: rtl/poly_pointwise_mul_if.sv
// Bus bundle between poly_pointwise_mul and its operand RAMs (A, B) and result RAM.
// POINTWISE_ACC_EN adds the result read port used by the accumulating variant.
interface poly_pointwise_mul_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] a_addr;
    logic [15:0]       a_dout;
    logic [ADDR_W-1:0] b_addr;
    logic [15:0]       b_dout;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_din;
`ifdef POINTWISE_ACC_EN
    logic [ADDR_W-1:0] r_raddr;
    logic [15:0]       r_dout;
`endif

    modport master (
        output start, a_dout, b_dout,
`ifdef POINTWISE_ACC_EN
        output r_dout,
        input  r_raddr,
`endif
        input  busy, done, a_addr, b_addr, r_we, r_addr, r_din
    );

    modport slave (
        input  start, a_dout, b_dout,
`ifdef POINTWISE_ACC_EN
        input  r_dout,
        output r_raddr,
`endif
        output busy, done, a_addr, b_addr, r_we, r_addr, r_din
    );
endinterface

// File: rtl/poly_pointwise_mul.sv
// r[i] = a[i]*b[i] mod Q (POINTWISE_ACC_EN: + r_old[i]), one coeff/cycle, write latency 4 (5 with acc).
// No backpressure: a pass streams all N coefficients; start is only honoured in IDLE.
module poly_pointwise_mul #(
    parameter int N      = 512,
    parameter int ADDR_W = 9,
    parameter int Q      = 12289,
    parameter int BAR_M  = 43687,
    parameter int BAR_S  = 29
) (
    input  logic                clk,
    input  logic                rst,
    poly_pointwise_mul_if.slave bus
);
`ifdef POINTWISE_ACC_EN
    localparam int P_W = 29;
    localparam int T_W = 16;
`else
    localparam int P_W = 28;
    localparam int T_W = 15;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [ADDR_W-1:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [P_W-1:0]    p_q, p_d, p3_q, p3_d;
    logic [T_W-1:0]    t_q, t_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       din_q, din_d;
`ifdef POINTWISE_ACC_EN
    logic              v4_q, v4_d;
    logic [ADDR_W-1:0] k4_q, k4_d;
    logic [14:0]       u4_q, u4_d;
`endif
    logic [44:0]       bar_prod;
    logic [14:0]       u_cur, u_out, r_val;
    logic              v_out;
    logic [ADDR_W-1:0] k_out;
    logic              unused_dout;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                busy_d  = 1'b1;
                addr_d  = '0;
            end
            RUN: begin
                // Counter parks at the last address; a pass never wraps.
                if (addr_q == LAST) state_d = DRAIN;
                else                addr_d  = addr_q + 1'b1;
            end
            DRAIN: if (we_q && waddr_q == LAST) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        v1_d = (state_q == RUN);
        k1_d = addr_q;
        v2_d = v1_q;
        k2_d = k1_q;
`ifdef POINTWISE_ACC_EN
        p_d  = P_W'(bus.a_dout[13:0]) * P_W'(bus.b_dout[13:0]) + P_W'(bus.r_dout[13:0]);
`else
        p_d  = P_W'(bus.a_dout[13:0]) * P_W'(bus.b_dout[13:0]);
`endif
        v3_d     = v2_q;
        k3_d     = k2_q;
        p3_d     = p_q;
        bar_prod = 45'(p_q) * 45'(BAR_M);
        t_d      = T_W'(bar_prod >> BAR_S);

        // Barrett quotient undershoots by at most one, so u stays below 2Q.
        u_cur = 15'(p3_q - P_W'(t_q) * P_W'(Q));
`ifdef POINTWISE_ACC_EN
        v4_d  = v3_q;
        k4_d  = k3_q;
        u4_d  = u_cur;
        u_out = u4_q;
        v_out = v4_q;
        k_out = k4_q;
`else
        u_out = u_cur;
        v_out = v3_q;
        k_out = k3_q;
`endif
        r_val   = (u_out >= 15'(Q)) ? u_out - 15'(Q) : u_out;
        we_d    = v_out;
        waddr_d = k_out;
        din_d   = {1'b0, r_val};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            p_q     <= '0;
            p3_q    <= '0;
            t_q     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
`ifdef POINTWISE_ACC_EN
            v4_q    <= 1'b0;
            k4_q    <= '0;
            u4_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            p_q     <= p_d;
            p3_q    <= p3_d;
            t_q     <= t_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
`ifdef POINTWISE_ACC_EN
            v4_q    <= v4_d;
            k4_q    <= k4_d;
            u4_q    <= u4_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_addr = addr_q;
    assign bus.b_addr = addr_q;
    assign bus.r_we   = we_q;
    assign bus.r_addr = waddr_q;
    assign bus.r_din  = din_q;
`ifdef POINTWISE_ACC_EN
    assign bus.r_raddr = addr_q;
    assign unused_dout = ^{bus.a_dout[15:14], bus.b_dout[15:14], bus.r_dout[15:14]};
`else
    assign unused_dout = ^{bus.a_dout[15:14], bus.b_dout[15:14]};
`endif
endmodule

// File: tb/tb_poly_pointwise_mul.sv
// Bench for poly_pointwise_mul: RAM models, constant-fill vector table, ramp/random passes vs a modular-arithmetic model.
module tb_poly_pointwise_mul;
    localparam int N = 512;
    localparam int Q = 12289;
`ifdef POINTWISE_ACC_EN
    localparam int L = 5;
`else
    localparam int L = 4;
`endif

    logic clk;
    logic rst;
    poly_pointwise_mul_if #(.ADDR_W(9)) bus ();
    poly_pointwise_mul dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] a_mem  [N];
    logic [15:0] b_mem  [N];
    logic [15:0] r_mem  [N];
    logic [15:0] r_init [N];
    logic        r_fill;

    int total, bad;
    int we_cnt, first_we, last_we, first_addr, last_addr;
    int done_cnt, done_cyc, over_q, seq_err, busy1, busy_end;

    typedef struct { int a; int b; int r; } vec_t;
    vec_t tv [7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        bus.a_dout <= a_mem[bus.a_addr];
        bus.b_dout <= b_mem[bus.b_addr];
`ifdef POINTWISE_ACC_EN
        bus.r_dout <= r_mem[bus.r_raddr];
`endif
        if (r_fill)         r_mem <= r_init;
        else if (bus.r_we)  r_mem[bus.r_addr] <= bus.r_din;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_r(input int i);
        longint p;
        p = longint'(a_mem[i] & 16'h3fff) * longint'(b_mem[i] & 16'h3fff);
`ifdef POINTWISE_ACC_EN
        p = p + longint'(r_init[i] & 16'h3fff);
`endif
        return int'(p % longint'(Q));
    endfunction

    task automatic preload_r();
        @(negedge clk); r_fill = 1'b1;
        @(negedge clk); r_fill = 1'b0;
    endtask

    task automatic run_pass(input int poke_a, input int poke_b);
        we_cnt = 0; first_we = -1; last_we = -1; first_addr = -1; last_addr = -1;
        done_cnt = 0; done_cyc = -1; over_q = 0; seq_err = 0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        busy1 = int'(bus.busy);
        for (int rel = 1; rel <= N + 40; rel++) begin
            if (bus.r_we) begin
                if (we_cnt == 0) begin first_we = rel; first_addr = int'(bus.r_addr); end
                last_we   = rel;
                last_addr = int'(bus.r_addr);
                if (int'(bus.r_addr) != we_cnt) seq_err++;
                if (int'(bus.r_din) >= Q) over_q++;
                we_cnt++;
            end
            if (bus.done) begin done_cnt++; done_cyc = rel; end
            bus.start = (rel == poke_a) || (rel == poke_b);
            @(negedge clk);
        end
        bus.start = 1'b0;
        busy_end  = int'(bus.busy);
    endtask

    task automatic check_pass(input string name);
        int errs;
        check({name, "_we_cnt"}, we_cnt, N);
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_addr_seq_err"}, seq_err, 0);
        check({name, "_ge_q"}, over_q, 0);
        errs = 0;
        for (int i = 0; i < N; i++)
            if (int'(r_mem[i]) != model_r(i)) errs++;
        check({name, "_model_errs"}, errs, 0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) begin
            a_mem[i] = 16'(i); b_mem[i] = 16'(i); r_init[i] = 16'd0;
        end
        preload_r();
    endtask

    initial begin
        int errs, hits;
        tv[0] = '{1, 1, 1};
        tv[1] = '{16383, 16383, 10929};
        tv[2] = '{0, 12345, 0};
        tv[3] = '{12289, 7, 0};
        tv[4] = '{16387, 3, 9};
        tv[5] = '{12288, 12288, 1};
        tv[6] = '{65535, 2, 8188};
        total = 0; bad = 0;
        rst = 1'b1; bus.start = 1'b0; r_fill = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_mem[i] = '0; b_mem[i] = '0; r_init[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_r_we", int'(bus.r_we), 0);
        check("rst_a_addr", int'(bus.a_addr), 0);
        check("rst_b_addr", int'(bus.b_addr), 0);
        check("rst_r_addr", int'(bus.r_addr), 0);
        check("rst_r_din", int'(bus.r_din), 0);
        rst = 1'b0;
        preload_r();

        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < N; i++) begin
                a_mem[i] = 16'(tv[t].a); b_mem[i] = 16'(tv[t].b); r_init[i] = 16'd0;
            end
            preload_r();
            run_pass(-1, -1);
            check_pass($sformatf("vec%0d", t));
            errs = 0;
            for (int i = 0; i < N; i++) if (int'(r_mem[i]) != tv[t].r) errs++;
            check($sformatf("vec%0d_const_errs", t), errs, 0);
        end

        fill_ramp();
        run_pass(-1, -1);
        check_pass("ramp");
        check("ramp_r3", int'(r_mem[3]), 9);
        check("ramp_r511", int'(r_mem[511]), 3052);
        check("ramp_r0", int'(r_mem[0]), 0);

        // Timing, with ignored starts mid-pass and in the done cycle.
        fill_ramp();
        run_pass(200, N + L + 1);
        check("t_busy_c1", busy1, 1);
        check("t_first_we", first_we, L + 1);
        check("t_first_addr", first_addr, 0);
        check("t_last_we", last_we, N + L);
        check("t_last_addr", last_addr, N - 1);
        check("t_done_cyc", done_cyc, N + L + 1);
        check("t_done_cnt", done_cnt, 1);
        check("t_we_cnt", we_cnt, N);
        check("t_busy_end", busy_end, 0);

        // A start in the cycle after done begins a new pass.
        fill_ramp();
        run_pass(N + L + 2, -1);
        check("restart_busy", busy_end, 1);
        hits = 0;
        for (int i = 0; i < N + 20; i++) begin
            if (bus.done) begin hits = 1; break; end
            @(negedge clk);
        end
        check("restart_done_seen", hits, 1);
        repeat (3) @(negedge clk);

        // Reset mid-pass.
        fill_ramp();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int i = 0; i < N && int'(bus.a_addr) != 100; i++) @(negedge clk);
        check("mid_rst_at_addr", int'(bus.a_addr), 100);
        rst = 1'b1;
        #1;
        check("mid_rst_r_we", int'(bus.r_we), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.r_we || bus.busy) hits++;
        end
        check("mid_rst_quiet", hits, 0);
        fill_ramp();
        run_pass(-1, -1);
        check_pass("after_rst");
        check("after_rst_r511", int'(r_mem[511]), 3052);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N; i++) begin
                a_mem[i]  = 16'($urandom);
                b_mem[i]  = 16'($urandom);
                r_init[i] = 16'($urandom);
            end
            if (pass == 0) begin
                a_mem[0] = 16'hffff; b_mem[0] = 16'hffff; r_init[0] = 16'hffff;
            end
            preload_r();
            run_pass(-1, -1);
            check_pass($sformatf("rand%0d", pass));
        end

`ifdef POINTWISE_ACC_EN
        for (int i = 0; i < N; i++) begin
            a_mem[i] = 16'd1; b_mem[i] = 16'd1; r_init[i] = 16'd12288;
        end
        preload_r();
        run_pass(-1, -1);
        check_pass("acc_wrap");
        errs = 0;
        for (int i = 0; i < N; i++) if (r_mem[i] != 16'd0) errs++;
        check("acc_wrap_zero_errs", errs, 0);
        check("acc_done_cyc", done_cyc, N + 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
